// File: rtl/timer_countdown_datapath.sv
// timer_countdown_datapath
//   Datapath for the mm:ss countdown timer. Latches switch-entered BCD time
//   (clamped digit-wise), counts it down once per second while decEn is high,
//   flags 00:00 back to the controller, and drives the LED flash pattern.
//
// Parameters
//   CLK_HZ  input clock frequency; the prescaler wraps at CLK_HZ-1
//   LED_W   width of the ledr output
//
// Ports
//   clk         system clock
//   reset       synchronous, active-low reset
//   sw[7:0]     BCD entry: sw[7:4] tens digit, sw[3:0] ones digit
//   swSecEn     load seconds digits from sw (every cycle while high)
//   swMinEn     load minutes digits from sw (every cycle while high)
//   decEn       run the countdown
//   flashEn     flash the LEDs (time expired)
//   min_tens, min_ones, sec_tens, sec_ones   registered BCD time
//   tick        one-cycle strobe, once per CLK_HZ cycles while running
//   isTimeFlat  all four digits are zero (combinational from digit regs)
//   ledr        LED flash pattern
//
// Build option
//   TIMER_LED_CHASE_EN  defined: a single lit LED rotates left on each tick.
//                       undefined: all LEDs toggle together on each tick.

module timer_countdown_datapath #(
  parameter int CLK_HZ = 50_000_000,
  parameter int LED_W  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       sw,
  input  logic             swSecEn,
  input  logic             swMinEn,
  input  logic             decEn,
  input  logic             flashEn,
  output logic [3:0]       min_tens,
  output logic [3:0]       min_ones,
  output logic [3:0]       sec_tens,
  output logic [3:0]       sec_ones,
  output logic             tick,
  output logic             isTimeFlat,
  output logic [LED_W-1:0] ledr
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

  logic [3:0]       min_tens_q, min_tens_d;
  logic [3:0]       min_ones_q, min_ones_d;
  logic [3:0]       sec_tens_q, sec_tens_d;
  logic [3:0]       sec_ones_q, sec_ones_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LED_W-1:0] ledr_q, ledr_d;
  logic             flash_prev_q, flash_prev_d;
  logic             run;
  logic [3:0]       sw_tens_sec, sw_tens_min, sw_ones;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_val);
    return (d > max_val) ? max_val : d;
  endfunction

  // Seconds tens saturates at 5; every other digit at 9.
  assign sw_tens_sec = clamp_digit(sw[7:4], 4'd5);
  assign sw_tens_min = clamp_digit(sw[7:4], 4'd9);
  assign sw_ones     = clamp_digit(sw[3:0], 4'd9);

  assign run        = decEn | flashEn;
  assign tick       = run && (cnt_q == CNT_LAST);
  assign isTimeFlat = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                      (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);

  // Prescaler: cleared whenever nothing needs it, so a resume always waits
  // a full second before the next tick.
  always_comb begin
    cnt_d = '0;
    if (run && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Digits: load beats decrement; the decrement borrows through the chain.
  always_comb begin
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    if (swSecEn || swMinEn) begin
      if (swSecEn) begin
        sec_tens_d = sw_tens_sec;
        sec_ones_d = sw_ones;
      end
      if (swMinEn) begin
        min_tens_d = sw_tens_min;
        min_ones_d = sw_ones;
      end
    end else if (tick && decEn && !isTimeFlat) begin
      if (sec_ones_q != 4'd0) begin
        sec_ones_d = sec_ones_q - 4'd1;
      end else begin
        sec_ones_d = 4'd9;
        if (sec_tens_q != 4'd0) begin
          sec_tens_d = sec_tens_q - 4'd1;
        end else begin
          sec_tens_d = 4'd5;
          if (min_ones_q != 4'd0) begin
            min_ones_d = min_ones_q - 4'd1;
          end else begin
            // Not flat, so min_tens is nonzero here.
            min_ones_d = 4'd9;
            min_tens_d = min_tens_q - 4'd1;
          end
        end
      end
    end
  end

  // LED pattern: seeded on the rising edge of flashEn, advanced on tick.
  always_comb begin
    flash_prev_d = flashEn;
    ledr_d       = ledr_q;
    if (!flashEn) begin
      ledr_d = '0;
    end else if (!flash_prev_q) begin
`ifdef TIMER_LED_CHASE_EN
      ledr_d = LED_W'(1);
`else
      ledr_d = '0;
`endif
    end else if (tick) begin
`ifdef TIMER_LED_CHASE_EN
      ledr_d = (ledr_q << 1) | (ledr_q >> (LED_W - 1));
`else
      ledr_d = ~ledr_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      min_tens_q   <= '0;
      min_ones_q   <= '0;
      sec_tens_q   <= '0;
      sec_ones_q   <= '0;
      cnt_q        <= '0;
      ledr_q       <= '0;
      flash_prev_q <= 1'b0;
    end else begin
      min_tens_q   <= min_tens_d;
      min_ones_q   <= min_ones_d;
      sec_tens_q   <= sec_tens_d;
      sec_ones_q   <= sec_ones_d;
      cnt_q        <= cnt_d;
      ledr_q       <= ledr_d;
      flash_prev_q <= flash_prev_d;
    end
  end

  assign min_tens = min_tens_q;
  assign min_ones = min_ones_q;
  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;
  assign ledr     = ledr_q;

endmodule

// File: tb/tb_timer_countdown_datapath.sv
// Directed bench for timer_countdown_datapath with CLK_HZ=4.
// Inputs change and outputs are sampled 1 ns after the rising edge.

module tb_timer_countdown_datapath;

  localparam int CLK_HZ = 4;
  localparam int LED_W  = 10;

`ifdef TIMER_LED_CHASE_EN
  localparam logic [LED_W-1:0] LED_P0 = 10'h001;
  localparam logic [LED_W-1:0] LED_P1 = 10'h002;
  localparam logic [LED_W-1:0] LED_P2 = 10'h004;
  localparam logic [LED_W-1:0] LED_P3 = 10'h008;
`else
  localparam logic [LED_W-1:0] LED_P0 = 10'h000;
  localparam logic [LED_W-1:0] LED_P1 = 10'h3FF;
  localparam logic [LED_W-1:0] LED_P2 = 10'h000;
  localparam logic [LED_W-1:0] LED_P3 = 10'h3FF;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       sw;
  logic             swSecEn, swMinEn, decEn, flashEn;
  logic [3:0]       min_tens, min_ones, sec_tens, sec_ones;
  logic             tick, isTimeFlat;
  logic [LED_W-1:0] ledr;
  logic [15:0]      time_bcd;

  int checks_cnt   = 0;
  int failures_cnt = 0;

  timer_countdown_datapath #(.CLK_HZ(CLK_HZ), .LED_W(LED_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .sw         (sw),
    .swSecEn    (swSecEn),
    .swMinEn    (swMinEn),
    .decEn      (decEn),
    .flashEn    (flashEn),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .tick       (tick),
    .isTimeFlat (isTimeFlat),
    .ledr       (ledr)
  );

  always #5 clk = ~clk;

  assign time_bcd = {min_tens, min_ones, sec_tens, sec_ones};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      failures_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_time(input logic [7:0] mm, input logic [7:0] ss);
    decEn   = 1'b0;
    swMinEn = 1'b1;
    sw      = mm;
    step(1);
    swMinEn = 1'b0;
    swSecEn = 1'b1;
    sw      = ss;
    step(1);
    swSecEn = 1'b0;
  endtask

  initial begin
    reset = 1'b0; sw = 8'h00;
    swSecEn = 1'b0; swMinEn = 1'b0; decEn = 1'b0; flashEn = 1'b0;
    step(2);
    check_val("rst_time", time_bcd, 16'h0000);
    check_val("rst_tick", tick, 1'b0);
    check_val("rst_ledr", ledr, 10'h000);
    check_val("rst_flat", isTimeFlat, 1'b1);
    reset = 1'b1;

    // Clamp / load
    swSecEn = 1'b1; sw = 8'h7C; step(1);
    check_val("clamp_7C", time_bcd, 16'h0059);
    sw = 8'hA7; step(1);
    check_val("clamp_A7", time_bcd, 16'h0057);
    sw = 8'h7C; step(1);
    swSecEn = 1'b0; swMinEn = 1'b1; sw = 8'h12; step(1);
    check_val("load_min", time_bcd, 16'h1259);
    check_val("load_flat", isTimeFlat, 1'b0);
    sw = 8'hFF; step(1);
    check_val("clamp_min_FF", time_bcd, 16'h9959);
    swMinEn = 1'b0;

    // Borrow chain from 10:00
    load_time(8'h10, 8'h00);
    decEn = 1'b1;
    step(2);
    check_val("bor_no_tick", tick, 1'b0);
    step(1);
    check_val("bor_tick1", tick, 1'b1);
    check_val("bor_pre", time_bcd, 16'h1000);
    step(1);
    check_val("bor_0959", time_bcd, 16'h0959);
    check_val("bor_tick_low", tick, 1'b0);
    step(3);
    check_val("bor_tick2", tick, 1'b1);
    step(1);
    check_val("bor_0958", time_bcd, 16'h0958);

    // Expiry from 00:02
    load_time(8'h00, 8'h02);
    decEn = 1'b1;
    step(4);
    check_val("exp_0001", time_bcd, 16'h0001);
    step(3);
    check_val("exp_flat_pre", isTimeFlat, 1'b0);
    step(1);
    check_val("exp_0000", time_bcd, 16'h0000);
    check_val("exp_flat", isTimeFlat, 1'b1);
    step(8);
    check_val("exp_hold", time_bcd, 16'h0000);

    // Pause / resume from 00:30
    load_time(8'h00, 8'h30);
    decEn = 1'b1;
    step(4);
    check_val("pau_0029", time_bcd, 16'h0029);
    step(2);
    decEn = 1'b0;
    step(6);
    check_val("pau_hold", time_bcd, 16'h0029);
    check_val("pau_tick", tick, 1'b0);
    decEn = 1'b1;
    step(2);
    check_val("res_early", tick, 1'b0);
    step(1);
    check_val("res_tick", tick, 1'b1);
    step(1);
    check_val("res_0028", time_bcd, 16'h0028);
    decEn = 1'b0;
    step(1);

    // Flash
    flashEn = 1'b1;
    step(1);
    check_val("fl_p0", ledr, LED_P0);
    step(2);
    check_val("fl_tick", tick, 1'b1);
    step(1);
    check_val("fl_p1", ledr, LED_P1);
    check_val("fl_digits", time_bcd, 16'h0028);
    step(4);
    check_val("fl_p2", ledr, LED_P2);
    step(4);
    check_val("fl_p3", ledr, LED_P3);
    flashEn = 1'b0;
    step(1);
    check_val("fl_off", ledr, 10'h000);

    // Load wins over a coincident decrement
    decEn = 1'b1; swSecEn = 1'b1; sw = 8'h15;
    step(4);
    check_val("prio_load", time_bcd, 16'h0015);
    swSecEn = 1'b0;
    step(4);
    check_val("prio_dec", time_bcd, 16'h0014);

    // Reset mid-run at 05:43
    load_time(8'h05, 8'h43);
    decEn = 1'b1; flashEn = 1'b1;
    step(2);
    check_val("mid_pre", time_bcd, 16'h0543);
    reset = 1'b0; swSecEn = 1'b1; sw = 8'h59;
    step(1);
    check_val("mid_time", time_bcd, 16'h0000);
    check_val("mid_ledr", ledr, 10'h000);
    check_val("mid_tick", tick, 1'b0);
    check_val("mid_flat", isTimeFlat, 1'b1);
    step(3);
    check_val("mid_tick_hold", tick, 1'b0);
    reset = 1'b1; swSecEn = 1'b0; decEn = 1'b0; flashEn = 1'b0;
    step(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
    $finish;
  end

endmodule
